lsu: RTL and testbench

Load/store unit between the single-cycle core datapath and data memory. It takes the ALU address and store data for the current load/store instruction and runs a req/ack transaction on a word-wide memory port, with byte enables, byte-lane alignment, load sign/zero extension and a bounded-wait timeout. It drives `busy` so the core holds PC and register writeback until the result is available on `rdata`, which feeds the datapath `read_data` input.

---
 rtl/lsu.sv | 259 +++++++++++++++++++++++++
 tb/tb_lsu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: load/store unit between the core datapath and a word-wide req/ack
// data memory port. Handles byte enables, store lane replication, load lane
// selection with sign/zero extension, illegal width detection and a bounded
// wait on mem_ack.
//
// Optional feature macro: LSU_MISALIGN_EXC_EN
//   defined   -> misaligned accesses skip memory and complete with misaligned_o=1
//   undefined -> misaligned_o tied low; accesses proceed on the aligned address
module lsu #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        misaligned_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] TMO_C = 32'(TIMEOUT);

    // Width code is legal for the access direction.
    function automatic logic legal_f(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b011, 3'b110, 3'b111: ok = 1'b0;
                default:                ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

`ifdef LSU_MISALIGN_EXC_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes never misalign.
    function automatic logic misal_f(input logic [2:0] f3, input logic [1:0] lo);
        logic m;
        case (f3[1:0])
            2'b01:   m = lo[0];
            2'b10:   m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    // Byte enables for a store; loads always read the whole word.
    function automatic logic [3:0] store_be_f(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << lo;
            3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the width could target.
    function automatic logic [31:0] store_data_f(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {4{d[7:0]}};
            3'b001:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Select the addressed lane of the read word and extend it.
    function automatic logic [31:0] load_ext_f(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        misal_s;
    logic        expire_s;

`ifdef LSU_MISALIGN_EXC_EN
    assign misal_s = misal_f(funct3_i, addr_i[1:0]);
`else
    assign misal_s = 1'b0;
`endif

    // Expiry happens on the edge at which the wait count would reach TIMEOUT.
    assign expire_s = (TMO_C != 32'd0) && (cnt_q == (TMO_C - 32'd1));

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mis_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (!legal_f(we_i, funct3_i)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (misal_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        addr_d      = addr_i;
                        we_d        = we_i;
                        funct3_d    = funct3_i;
                        cnt_d       = 32'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = we_i;
                        mem_be_d    = we_i ? store_be_f(funct3_i, addr_i[1:0]) : 4'b1111;
                        mem_wdata_d = store_data_f(funct3_i, wdata_i);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_ext_f(funct3_q, addr_q[1:0], mem_rdata_i);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (expire_s) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset withdraws any pending request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            cnt_q       <= 32'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mis_q       <= mis_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stall is combinational so the core holds in the very cycle it issues.
    assign busy_o       = ((state_q == ST_IDLE) && start_i) || (state_q == ST_REQ);
    assign rdata_o      = rdata_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign misaligned_o = mis_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu. Expected completions are queued when an
// access is issued and compared when done_o pulses.
module tb_lsu;

    localparam int TMO = 7;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        misaligned_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    lsu #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .we_i         (we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .misaligned_o (misaligned_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one access from IDLE (called #1 after a rising edge) and follow it
    // to completion. ack_at is the REQ cycle number carrying mem_ack (0 = never).
    task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                          input logic exp_mem, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic exp_mis);
        exp_t e;
        int   cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.mis   = exp_mis;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        start_i     = 1'b1;
        we_i        = w;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        mem_rdata_i = rd;
        #1;
        check("busy_start", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc     = 1;
        while (!done_o && cyc < 40) begin
            if (exp_mem) begin
                check("req_hold", {31'd0, mem_req_o}, 32'd1);
                check("req_addr", mem_addr_o, {a[31:2], 2'b00});
                check("req_be", {28'd0, mem_be_o}, {28'd0, exp_be});
                check("req_we", {31'd0, mem_we_o}, {31'd0, w});
                if (w) check("req_wdata", mem_wdata_o, exp_wd);
            end else begin
                check("no_req", {31'd0, mem_req_o}, 32'd0);
            end
            check("busy_req", {31'd0, busy_o}, 32'd1);
            mem_ack_i = (cyc == ack_at);
            @(posedge clk); #1;
            mem_ack_i = 1'b0;
            cyc++;
        end
        if (!done_o) begin
            check("done_wait_expired", 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("rdata", rdata_o, e.rdata);
            check("err", {31'd0, err_o}, {31'd0, e.err});
            check("misaligned", {31'd0, misaligned_o}, {31'd0, e.mis});
            check("latency", cyc, e.lat);
            check("req_drop", {31'd0, mem_req_o}, 32'd0);
            check("busy_done", {31'd0, busy_o}, 32'd0);
        end
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        we_i        = 1'b0;
        funct3_i    = 3'd0;
        addr_i      = 32'd0;
        wdata_i     = 32'd0;
        mem_rdata_i = 32'd0;
        mem_ack_i   = 1'b0;
        #1;
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_flags", {26'd0, busy_o, done_o, err_o, misaligned_o, mem_req_o, mem_we_o}, 32'd0);
        check("rst_be", {28'd0, mem_be_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // mem_ack while idle must not start or complete anything
        mem_ack_i = 1'b1;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        check("idle_ack_done", {31'd0, done_o}, 32'd0);
        check("idle_ack_req", {31'd0, mem_req_o}, 32'd0);

        //     we    f3      addr          wdata          rdata         ack  mem   be       wd             lat    rdata         err   mis
        run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 1'b1, 4'b1111, 32'h0,         2,     32'hFFFF_FF80, 1'b0, 1'b0);
        run_op(1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0,       6, 1'b1, 4'b1100, 32'hBEEF_BEEF, 7,     32'hFFFF_FF80, 1'b0, 1'b0);
        run_op(1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_0000, 1, 1'b1, 4'b1111, 32'h0,         2,     32'h0000_8001, 1'b0, 1'b0);
        run_op(1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_8001, 2, 1'b1, 4'b1111, 32'h0,         3,     32'hFFFF_8001, 1'b0, 1'b0);
        run_op(1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h0000_F500, 1, 1'b1, 4'b1111, 32'h0,         2,     32'h0000_00F5, 1'b0, 1'b0);
        run_op(1'b1, 3'b000, 32'h0000_0003, 32'h1234_56A5, 32'h0,       1, 1'b1, 4'b1000, 32'hA5A5_A5A5, 2,     32'h0000_00F5, 1'b0, 1'b0);
        run_op(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,       3, 1'b1, 4'b1111, 32'hDEAD_BEEF, 4,     32'h0000_00F5, 1'b0, 1'b0);
        // timeout: no ack ever
        run_op(1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'h5555_5555, 0, 1'b1, 4'b1111, 32'h0,         TMO+1, 32'h0000_00F5, 1'b1, 1'b0);
        // illegal widths: no memory access
        run_op(1'b0, 3'b011, 32'h0000_0020, 32'h0,        32'h5555_5555, 1, 1'b0, 4'b0000, 32'h0,         1,     32'h0000_00F5, 1'b1, 1'b0);
        run_op(1'b1, 3'b100, 32'h0000_0020, 32'h1111_1111, 32'h0,       1, 1'b0, 4'b0000, 32'h0,         1,     32'h0000_00F5, 1'b1, 1'b0);
`ifdef LSU_MISALIGN_EXC_EN
        run_op(1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'hCAFE_F00D, 1, 1'b0, 4'b0000, 32'h0,         1,     32'h0000_00F5, 1'b0, 1'b1);
`else
        run_op(1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'hCAFE_F00D, 1, 1'b1, 4'b1111, 32'h0,         2,     32'hCAFE_F00D, 1'b0, 1'b0);
`endif
        // ack on the same edge as expiry: success wins
        run_op(1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'h0BAD_F00D, TMO, 1'b1, 4'b1111, 32'h0,       TMO+1, 32'h0BAD_F00D, 1'b0, 1'b0);

        // reset in the middle of REQ withdraws the request without a clock edge
        start_i  = 1'b1;
        we_i     = 1'b0;
        funct3_i = 3'b010;
        addr_i   = 32'h0000_0010;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_async_busy", {31'd0, busy_o}, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {30'd0, mem_req_o, done_o}, 32'd0);
        check("post_rst_rdata", rdata_o, 32'd0);
        run_op(1'b1, 3'b010, 32'h0000_0010, 32'h0123_4567, 32'h0, 1, 1'b1, 4'b1111, 32'h0123_4567, 2, 32'h0, 1'b0, 1'b0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
